sargantana_icache_ifill_arb: RTL and testbench



---
 rtl/sargantana_icache_ifill_arb.sv | 184 ++++++++++++++++++
 tb/tb_sargantana_icache_ifill_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_ifill_arb.sv
// Instruction-cache fill-port arbiter: shares the single upstream iFill port
// between the demand-miss path and the next-line prefetcher, keeps at most
// one line fill in flight, routes the returned line to its owner and drains
// the response of fills killed by the core or by a flush.
//
// Handshake: a requester holds *_valid_i until it sees *_ready_o in the same
// cycle; ready is only ever raised in IDLE. Upstream, up_req_valid_o stays
// high with stable address/way until up_ack_i is sampled (never retracted,
// even when the fill is killed). Responses are 1-cycle pulses on
// *_resp_valid_o with data/way qualified by them.
module sargantana_icache_ifill_arb #(
  parameter int PADDR_SIZE = 40,
  parameter int LINE_BITS  = 128,
  parameter int WAY_BITS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  dmd_valid_i,
  input  logic                  dmd_kill_i,
  input  logic [PADDR_SIZE-1:0] dmd_paddr_i,
  input  logic [WAY_BITS-1:0]   dmd_way_i,
  output logic                  dmd_ready_o,
  output logic                  dmd_resp_valid_o,
  input  logic                  pf_valid_i,
  input  logic [PADDR_SIZE-1:0] pf_paddr_i,
  input  logic [WAY_BITS-1:0]   pf_way_i,
  output logic                  pf_ready_o,
  output logic                  pf_resp_valid_o,
  output logic [LINE_BITS-1:0]  resp_data_o,
  output logic [WAY_BITS-1:0]   resp_way_o,
  output logic                  up_req_valid_o,
  output logic [PADDR_SIZE-1:0] up_req_paddr_o,
  output logic [WAY_BITS-1:0]   up_req_way_o,
  input  logic                  up_ack_i,
  input  logic                  up_resp_valid_i,
  input  logic [LINE_BITS-1:0]  up_resp_data_i,
  output logic                  busy_o,
  output logic                  kill_pulse_o,
  output logic [1:0]            dbg_state_o
);

  localparam int OFFS = $clog2(LINE_BITS / 8);
  localparam logic [PADDR_SIZE-1:0] ALIGN_MASK =
    {{(PADDR_SIZE - OFFS){1'b1}}, {OFFS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMD  = 2'd1,
    OWN_PF   = 2'd2
  } owner_t;

  state_t                r_state;
  state_t                w_state_nxt;
  owner_t                r_owner;
  logic                  r_kill_pend;
  logic [PADDR_SIZE-1:0] r_paddr;
  logic [WAY_BITS-1:0]   r_way;
  logic [LINE_BITS-1:0]  r_resp_data;
  logic [WAY_BITS-1:0]   r_resp_way;
  logic                  r_dmd_resp;
  logic                  r_pf_resp;
  logic                  r_kill_pulse;

  logic w_idle;
  logic w_dmd_grant;
  logic w_pf_grant;
  logic w_kill;
  logic w_kill_new;
  logic w_complete;

  // Grant, kill and completion decode shared by the FSM and the datapath.
  // Grants are masked while reset is asserted so the ready outputs read 0.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_dmd_grant = w_idle & ~rst_i & ~flush_i & dmd_valid_i & ~dmd_kill_i;
    w_pf_grant  = w_idle & ~rst_i & ~flush_i & pf_valid_i &
                  ~(dmd_valid_i & ~dmd_kill_i);
    // A core kill only concerns fills the demand path owns.
    w_kill      = flush_i | (dmd_kill_i & (r_owner == OWN_DMD));
    // Counted once per transaction: REQ with a kill already pending and
    // DRAIN are already doomed and must not re-pulse.
    w_kill_new  = w_kill & (((r_state == S_REQ) & ~r_kill_pend) |
                            (r_state == S_WAIT));
    w_complete  = ~w_kill & (
                    ((r_state == S_REQ) & ~r_kill_pend & up_ack_i & up_resp_valid_i) |
                    ((r_state == S_WAIT) & up_resp_valid_i));
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a kill coinciding with the response drops the line
  // and returns straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dmd_grant | w_pf_grant) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (up_ack_i) begin
          if (up_resp_valid_i)            w_state_nxt = S_IDLE;
          else if (w_kill | r_kill_pend)  w_state_nxt = S_DRAIN;
          else                            w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (up_resp_valid_i) w_state_nxt = S_IDLE;
        else if (w_kill)     w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (up_resp_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current state and the grant logic.
  always_comb begin
    dmd_ready_o      = w_dmd_grant;
    pf_ready_o       = w_pf_grant;
    up_req_valid_o   = (r_state == S_REQ);
    busy_o           = (r_state != S_IDLE);
    dbg_state_o      = r_state;
    up_req_paddr_o   = r_paddr;
    up_req_way_o     = r_way;
    resp_data_o      = r_resp_data;
    resp_way_o       = r_resp_way;
    dmd_resp_valid_o = r_dmd_resp;
    pf_resp_valid_o  = r_pf_resp;
    kill_pulse_o     = r_kill_pulse;
  end

  // Request capture, owner tracking, kill bookkeeping and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner      <= OWN_NONE;
      r_kill_pend  <= 1'b0;
      r_paddr      <= '0;
      r_way        <= '0;
      r_resp_data  <= '0;
      r_resp_way   <= '0;
      r_dmd_resp   <= 1'b0;
      r_pf_resp    <= 1'b0;
      r_kill_pulse <= 1'b0;
    end else begin
      if (w_dmd_grant) begin
        r_owner <= OWN_DMD;
        r_paddr <= dmd_paddr_i & ALIGN_MASK;
        r_way   <= dmd_way_i;
      end else if (w_pf_grant) begin
        r_owner <= OWN_PF;
        r_paddr <= pf_paddr_i & ALIGN_MASK;
        r_way   <= pf_way_i;
      end else if (w_state_nxt == S_IDLE) begin
        r_owner <= OWN_NONE;
      end
      // Remember a kill seen before the ack, cleared once REQ is left.
      r_kill_pend  <= (r_state == S_REQ) & ~up_ack_i & (r_kill_pend | w_kill);
      r_kill_pulse <= w_kill_new;
      r_dmd_resp   <= w_complete & (r_owner == OWN_DMD);
      r_pf_resp    <= w_complete & (r_owner == OWN_PF);
      if (w_complete) begin
        r_resp_data <= up_resp_data_i;
        r_resp_way  <= r_way;
      end
    end
  end

endmodule

// File: tb/tb_sargantana_icache_ifill_arb.sv
// Directed bench for sargantana_icache_ifill_arb: demand fill, arbitration,
// kills in REQ/WAIT, flush racing the response, and reset mid-transaction.
module tb_sargantana_icache_ifill_arb;

  localparam int PA = 40;
  localparam int LB = 128;
  localparam int WB = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush, dmd_valid, dmd_kill, pf_valid;
  logic [PA-1:0] dmd_paddr, pf_paddr;
  logic [WB-1:0] dmd_way, pf_way;
  logic          up_ack, up_resp_valid;
  logic [LB-1:0] up_resp_data;
  logic          dmd_ready, dmd_resp_valid, pf_ready, pf_resp_valid;
  logic [LB-1:0] resp_data;
  logic [WB-1:0] resp_way, up_req_way;
  logic          up_req_valid, busy, kill_pulse;
  logic [PA-1:0] up_req_paddr;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  sargantana_icache_ifill_arb #(.PADDR_SIZE(PA), .LINE_BITS(LB), .WAY_BITS(WB)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dmd_valid_i(dmd_valid), .dmd_kill_i(dmd_kill), .dmd_paddr_i(dmd_paddr),
    .dmd_way_i(dmd_way), .dmd_ready_o(dmd_ready), .dmd_resp_valid_o(dmd_resp_valid),
    .pf_valid_i(pf_valid), .pf_paddr_i(pf_paddr), .pf_way_i(pf_way),
    .pf_ready_o(pf_ready), .pf_resp_valid_o(pf_resp_valid),
    .resp_data_o(resp_data), .resp_way_o(resp_way),
    .up_req_valid_o(up_req_valid), .up_req_paddr_o(up_req_paddr),
    .up_req_way_o(up_req_way), .up_ack_i(up_ack),
    .up_resp_valid_i(up_resp_valid), .up_resp_data_i(up_resp_data),
    .busy_o(busy), .kill_pulse_o(kill_pulse), .dbg_state_o(dbg_state)
  );

  // driver tasks: advance to 1 time unit after the rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [PA-1:0] obs, input logic [PA-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    flush = 0; dmd_valid = 0; dmd_kill = 0; pf_valid = 0;
    dmd_paddr = '0; pf_paddr = '0; dmd_way = '0; pf_way = '0;
    up_ack = 0; up_resp_valid = 0; up_resp_data = '0;

    // reset state
    repeat (3) tick();
    settle();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_upreq", up_req_valid, 1'b0);
    chk1("rst_dresp", dmd_resp_valid, 1'b0);
    chk1("rst_presp", pf_resp_valid, 1'b0);
    chk1("rst_kill", kill_pulse, 1'b0);
    chkw("rst_data", resp_data, '0);
    chk2("rst_state", dbg_state, 2'd0);
    rst = 0;

    // grant blocking: flush blocks all, dmd_kill blocks demand only
    tick();
    dmd_valid = 1; flush = 1; pf_valid = 1;
    settle();
    chk1("flush_blk_d", dmd_ready, 1'b0);
    chk1("flush_blk_p", pf_ready, 1'b0);
    flush = 0; dmd_kill = 1;
    settle();
    chk1("kill_blk_d", dmd_ready, 1'b0);
    chk1("kill_pf_ok", pf_ready, 1'b1);
    dmd_valid = 0; dmd_kill = 0; pf_valid = 0;
    settle();

    // 1) demand only: grant t, ack t+1, data t+3, pulse t+4
    tick();
    dmd_valid = 1; dmd_paddr = 40'h0080001234; dmd_way = 2'd2;
    settle();
    chk1("t1_ready", dmd_ready, 1'b1);
    chk1("t1_pfready", pf_ready, 1'b0);
    chk1("t1_busy0", busy, 1'b0);
    tick();                                    // t+1
    dmd_valid = 0; up_ack = 1;
    settle();
    chk1("t1_upreq", up_req_valid, 1'b1);
    chka("t1_paddr", up_req_paddr, 40'h0080001230);
    chk2("t1_way", up_req_way, 2'd2);
    chk1("t1_busy1", busy, 1'b1);
    tick();                                    // t+2
    up_ack = 0;
    settle();
    chk1("t1_upreq_lo", up_req_valid, 1'b0);
    chk1("t1_busy2", busy, 1'b1);
    tick();                                    // t+3
    up_resp_valid = 1; up_resp_data = {16{8'hA5}};
    settle();
    chk1("t1_busy3", busy, 1'b1);
    chk1("t1_noresp", dmd_resp_valid, 1'b0);
    tick();                                    // t+4
    up_resp_valid = 0;
    settle();
    chk1("t1_resp", dmd_resp_valid, 1'b1);
    chkw("t1_data", resp_data, {16{8'hA5}});
    chk2("t1_rway", resp_way, 2'd2);
    chk1("t1_busy4", busy, 1'b0);
    tick();
    settle();
    chk1("t1_resp_lo", dmd_resp_valid, 1'b0);

    // 2) simultaneous demand and prefetch, minimum turnaround for demand
    dmd_valid = 1; dmd_paddr = 40'h0000001008; dmd_way = 2'd1;
    pf_valid = 1; pf_paddr = 40'h000000201F; pf_way = 2'd3;
    settle();
    chk1("t2_dready", dmd_ready, 1'b1);
    chk1("t2_pblock", pf_ready, 1'b0);
    tick();
    dmd_valid = 0; up_ack = 1; up_resp_valid = 1; up_resp_data = {16{8'h11}};
    settle();
    chk1("t2_pf_wait", pf_ready, 1'b0);
    chka("t2_dpaddr", up_req_paddr, 40'h0000001000);
    tick();
    up_ack = 0; up_resp_valid = 0;
    settle();
    chk1("t2_dresp", dmd_resp_valid, 1'b1);
    chkw("t2_ddata", resp_data, {16{8'h11}});
    chk1("t2_pready", pf_ready, 1'b1);
    tick();
    pf_valid = 0; up_ack = 1;
    settle();
    chka("t2_ppaddr", up_req_paddr, 40'h0000002010);
    chk2("t2_pway", up_req_way, 2'd3);
    tick();
    up_ack = 0; up_resp_valid = 1; up_resp_data = {16{8'h22}};
    settle();
    tick();
    up_resp_valid = 0;
    settle();
    chk1("t2_presp", pf_resp_valid, 1'b1);
    chk1("t2_no_dresp", dmd_resp_valid, 1'b0);
    chkw("t2_pdata", resp_data, {16{8'h22}});
    chk2("t2_prway", resp_way, 2'd3);

    // 3) demand kill in REQ before ack: request held, data dropped
    tick();
    dmd_valid = 1; dmd_paddr = 40'h0000003000; dmd_way = 2'd0;
    settle();
    tick();
    dmd_valid = 0; dmd_kill = 1;
    settle();
    chk1("t3_req", up_req_valid, 1'b1);
    tick();
    dmd_kill = 0;
    settle();
    chk1("t3_kpulse", kill_pulse, 1'b1);
    chk1("t3_held", up_req_valid, 1'b1);
    tick();
    up_ack = 1;
    settle();
    chk1("t3_kpulse_lo", kill_pulse, 1'b0);
    chk1("t3_held2", up_req_valid, 1'b1);
    tick();
    up_ack = 0; up_resp_valid = 1; up_resp_data = {16{8'h33}};
    settle();
    chk1("t3_drain_req", up_req_valid, 1'b0);
    chk2("t3_drain", dbg_state, 2'd3);
    chk1("t3_kp_drain", kill_pulse, 1'b0);
    tick();
    up_resp_valid = 0;
    settle();
    chk1("t3_noresp", dmd_resp_valid, 1'b0);
    chk1("t3_idle", busy, 1'b0);
    chkw("t3_keep", resp_data, {16{8'h22}});

    // 4) flush in PF-owned WAIT together with the response
    tick();
    pf_valid = 1; pf_paddr = 40'h0000004000; pf_way = 2'd1;
    settle();
    chk1("t4_pready", pf_ready, 1'b1);
    tick();
    pf_valid = 0; up_ack = 1;
    settle();
    tick();
    up_ack = 0; flush = 1; up_resp_valid = 1; up_resp_data = {16{8'h44}};
    settle();
    chk2("t4_wait", dbg_state, 2'd2);
    tick();
    flush = 0; up_resp_valid = 0;
    settle();
    chk1("t4_noresp", pf_resp_valid, 1'b0);
    chk1("t4_kpulse", kill_pulse, 1'b1);
    chk1("t4_idle", busy, 1'b0);
    chkw("t4_keep", resp_data, {16{8'h22}});
    tick();
    settle();
    chk1("t4_kpulse_lo", kill_pulse, 1'b0);

    // 5) demand kill while prefetch owns the port
    pf_valid = 1; pf_paddr = 40'h0000005040; pf_way = 2'd2;
    settle();
    tick();
    pf_valid = 0; dmd_kill = 1; up_ack = 1;
    settle();
    tick();
    up_ack = 0; up_resp_valid = 1; up_resp_data = {16{8'h55}};
    settle();
    chk1("t5_nokill", kill_pulse, 1'b0);
    chk2("t5_wait", dbg_state, 2'd2);
    tick();
    dmd_kill = 0; up_resp_valid = 0;
    settle();
    chk1("t5_presp", pf_resp_valid, 1'b1);
    chkw("t5_data", resp_data, {16{8'h55}});
    chk1("t5_nokill2", kill_pulse, 1'b0);

    // 6) reset mid-WAIT, late data ignored
    tick();
    dmd_valid = 1; dmd_paddr = 40'h0000006000; dmd_way = 2'd1;
    settle();
    tick();
    dmd_valid = 0; up_ack = 1;
    settle();
    tick();
    up_ack = 0;
    settle();
    chk2("t6_wait", dbg_state, 2'd2);
    rst = 1;
    settle();
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_upreq", up_req_valid, 1'b0);
    chka("t6_paddr", up_req_paddr, '0);
    chkw("t6_data", resp_data, '0);
    chk2("t6_rway", resp_way, 2'd0);
    tick();
    rst = 0;
    tick();
    tick();
    up_resp_valid = 1; up_resp_data = {16{8'h66}};
    settle();
    tick();
    up_resp_valid = 0;
    settle();
    chk1("t6_no_dresp", dmd_resp_valid, 1'b0);
    chk1("t6_no_presp", pf_resp_valid, 1'b0);
    chkw("t6_data2", resp_data, '0);
    chk1("t6_idle", busy, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
